mips_control_fsm: RTL

//  Multi-cycle control sequencer for the MIPS core datapath.
//  - Latches opcode/funct of the fetched instruction.
//  - Steps the instruction through FETCH/DECODE/EXEC/MEM/WB.
//  - Drives the datapath selects (regDest, aluSrc, memOrReg, alu_operation), the write enables and halted.
//  - Sits between the instruction bus and data_path inside the core top level.

---
 rtl/mips_control_fsm_if.sv | 32 +++
 rtl/mips_control_fsm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm_if.sv
// Control bus between the multi-cycle sequencer (master) and the MIPS data_path (slave).
// Carries the latched instruction fields in, and the selects, strobes and status out.
interface mips_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             ir_load;
    logic             regDest;
    logic             aluSrc;
    logic             memOrReg;
    logic [3:0]       alu_operation;
    logic             write_enable;
    logic             mem_write_en;
    logic             pc_write_en;
    logic [1:0]       pc_src;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero,
        output ir_load, regDest, aluSrc, memOrReg, alu_operation,
               write_enable, mem_write_en, pc_write_en, pc_src, halted, retired
    );

    modport slave (
        output opcode, funct, zero,
        input  ir_load, regDest, aluSrc, memOrReg, alu_operation,
               write_enable, mem_write_en, pc_write_en, pc_src, halted, retired
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a HALT sink.
// Optional ILLEGAL_TRAP_EN: unsupported encodings halt the core instead of retiring as NOP.
module mips_control_fsm #(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    mips_control_fsm_if.master   bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;

    logic [2:0]       state, state_nxt;
    logic [5:0]       op_q, fn_q;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;

    logic       is_alu, is_imm, is_j, is_beq, is_bne, is_lw, is_sw, is_sys;
    logic [3:0] alu_op;
    logic       is_br, mem_last, taken, pc_we;

    always_comb begin
        is_alu = 1'b0;
        is_imm = 1'b0;
        is_j   = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_sys = 1'b0;
        alu_op = ALU_ADD;
        case (op_q)
            6'h00: begin
                case (fn_q)
                    6'h20, 6'h21: begin is_alu = 1'b1; alu_op = ALU_ADD; end
                    6'h22, 6'h23: begin is_alu = 1'b1; alu_op = ALU_SUB; end
                    6'h24:        begin is_alu = 1'b1; alu_op = ALU_AND; end
                    6'h25:        begin is_alu = 1'b1; alu_op = ALU_OR;  end
                    6'h26:        begin is_alu = 1'b1; alu_op = ALU_XOR; end
                    6'h27:        begin is_alu = 1'b1; alu_op = ALU_NOR; end
                    6'h2A:        begin is_alu = 1'b1; alu_op = ALU_SLT; end
                    6'h0C:        is_sys = 1'b1;
                    default:      ;
                endcase
            end
            6'h02:        is_j = 1'b1;
            6'h04:        begin is_beq = 1'b1; alu_op = ALU_SUB; end
            6'h05:        begin is_bne = 1'b1; alu_op = ALU_SUB; end
            6'h08, 6'h09: begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_ADD; end
            6'h0A:        begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_SLT; end
            6'h0C:        begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_AND; end
            6'h0D:        begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_OR;  end
            6'h0E:        begin is_alu = 1'b1; is_imm = 1'b1; alu_op = ALU_XOR; end
            6'h23:        is_lw = 1'b1;
            6'h2B:        is_sw = 1'b1;
            default:      ;
        endcase
    end

    assign is_br    = is_beq | is_bne;
    assign mem_last = (wait_cnt == 4'd0);
    assign taken    = (is_beq & bus.zero) | (is_bne & ~bus.zero);

    // The PC strobe marks every instruction's last cycle, so it also drives retirement.
    assign pc_we = rst_b & (((state == S_DECODE) & is_j) |
                            ((state == S_EXEC) & is_br) |
                            ((state == S_MEM) & is_sw & mem_last) |
                            (state == S_WB));

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_sys)
                    state_nxt = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                else if (!(is_alu | is_j | is_br | is_lw | is_sw))
                    state_nxt = S_HALT;
`endif
                else if (is_j)
                    state_nxt = S_FETCH;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_br)
                    state_nxt = S_FETCH;
                else if (is_lw | is_sw)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_last)
                    state_nxt = is_sw ? S_FETCH : S_WB;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S_FETCH;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            wait_cnt  <= 4'd0;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
            // Reload on the way into MEM so every memory access waits the full count.
            if (state == S_EXEC)
                wait_cnt <= 4'(MEM_WAIT);
            else if ((state == S_MEM) && !mem_last)
                wait_cnt <= wait_cnt - 4'd1;
            if (pc_we)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.ir_load       = rst_b & (state == S_FETCH);
    assign bus.regDest       = (op_q == 6'h00);
    assign bus.aluSrc        = is_imm | is_lw | is_sw;
    assign bus.memOrReg      = is_lw;
    assign bus.alu_operation = alu_op;
    assign bus.write_enable  = rst_b & (state == S_WB) & (is_alu | is_lw);
    assign bus.mem_write_en  = rst_b & (state == S_MEM) & is_sw & mem_last;
    assign bus.pc_write_en   = pc_we;
    assign bus.pc_src        = ((state == S_DECODE) & is_j) ? 2'd2 :
                               ((state == S_EXEC) & is_br & taken) ? 2'd1 : 2'd0;
    assign bus.halted        = (state == S_HALT);
    assign bus.retired       = retired_q;
endmodule
